// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush controller: MEM-stage exception codes,
// controller FSM states and stall-vector bit positions.
package pipeline_ctrl_pkg;

    localparam logic [31:0] EXC_NONE = 32'd0;
    localparam logic [31:0] EXC_INT  = 32'd1;
    localparam logic [31:0] EXC_ADEL = 32'd4;
    localparam logic [31:0] EXC_ADES = 32'd5;
    localparam logic [31:0] EXC_SYS  = 32'd8;
    localparam logic [31:0] EXC_BP   = 32'd9;
    localparam logic [31:0] EXC_RI   = 32'd10;
    localparam logic [31:0] EXC_OV   = 32'd12;
    localparam logic [31:0] EXC_ERET = 32'd14;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        WAIT_FETCH = 2'd1,
        FLUSH      = 2'd2
    } ctrl_state_e;

    localparam int STALL_PC     = 0;
    localparam int STALL_IF_ID  = 1;
    localparam int STALL_ID_EX  = 2;
    localparam int STALL_EX_MEM = 3;

    localparam logic [3:0] STALL_NONE = 4'b0000;
    localparam logic [3:0] STALL_ALL  = 4'b1111;

    // A stall at a stage freezes that stage and everything upstream of it.
    function automatic logic [3:0] stall_mask(input logic req_mem, input logic req_ex,
                                              input logic req_id, input logic req_if);
        logic [3:0] m;
        m = STALL_NONE;
        if (req_mem) begin
            m = STALL_ALL;
        end else if (req_ex) begin
            m[STALL_ID_EX:STALL_PC] = 3'b111;
        end else if (req_id) begin
            m[STALL_IF_ID:STALL_PC] = 2'b11;
        end else if (req_if) begin
            m[STALL_PC] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_perf.sv
// Saturating performance counters for stalled cycles and issued flushes.
// Only instantiated when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl_perf #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_evt,
    input  logic             flush_evt,
    output logic [CNT_W-1:0] perf_stall_cyc,
    output logic [CNT_W-1:0] perf_flush_cnt
);

    logic [CNT_W-1:0] stall_cyc_q, stall_cyc_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Counters stick at all-ones instead of wrapping back to a misleading small value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    always_comb begin
        stall_cyc_d = stall_cyc_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt) begin
            stall_cyc_d = sat_inc(stall_cyc_q);
        end
        if (flush_evt) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cyc_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cyc_q <= stall_cyc_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cyc = stall_cyc_q;
    assign perf_flush_cnt = flush_cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: stall priority encoder plus the
// RUN/WAIT_FETCH/FLUSH machine. Perf counters are built only with PIPE_CTRL_PERF_EN.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             if_busy,
    input  logic [31:0]      exception_type,
    input  logic [31:0]      cp0_epc,
    output logic [3:0]       stall,
    output logic             exception,
    output logic [31:0]      new_pc,
    output logic [CNT_W-1:0] perf_stall_cyc,
    output logic [CNT_W-1:0] perf_flush_cnt
);

    ctrl_state_e state_q, state_d;
    logic [31:0] pc_q, pc_d;

    logic        exc_hit;
    logic [31:0] exc_tgt;
    logic [3:0]  stall_c;
    logic        exception_c;
    logic [31:0] new_pc_c;

    always_comb begin
        exc_hit = (exception_type != EXC_NONE);
        exc_tgt = (exception_type == EXC_ERET) ? cp0_epc : EXC_VECTOR;
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        stall_c     = STALL_NONE;
        exception_c = 1'b0;
        new_pc_c    = '0;

        unique case (state_q)
            RUN: begin
                if (exc_hit && !if_busy) begin
                    exception_c = 1'b1;
                    new_pc_c    = exc_tgt;
                end else if (exc_hit) begin
                    // The outstanding AXI fetch cannot be cancelled: freeze everything
                    // and replay the redirect once the fetch has drained.
                    stall_c = STALL_ALL;
                    pc_d    = exc_tgt;
                    state_d = WAIT_FETCH;
                end else begin
                    stall_c = stall_mask(stallreq_mem, stallreq_ex, stallreq_id, stallreq_if);
                end
            end
            WAIT_FETCH: begin
                stall_c = STALL_ALL;
                if (!if_busy) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                exception_c = 1'b1;
                new_pc_c    = pc_q;
                state_d     = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Redirect target is pure data; it is only observed after being written in RUN.
    always_ff @(posedge clk) begin
        pc_q <= pc_d;
    end

    // Outputs drop to their idle values the moment reset asserts, even while an
    // exception code is still present on the MEM-stage inputs.
    always_comb begin
        stall     = rst ? STALL_NONE : stall_c;
        exception = rst ? 1'b0       : exception_c;
        new_pc    = rst ? '0         : new_pc_c;
    end

`ifdef PIPE_CTRL_PERF_EN
    pipeline_ctrl_perf #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk           (clk),
        .rst           (rst),
        .stall_evt     (stall != STALL_NONE),
        .flush_evt     (exception),
        .perf_stall_cyc(perf_stall_cyc),
        .perf_flush_cnt(perf_flush_cnt)
    );
`else
    assign perf_stall_cyc = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed vector table, multi-cycle sequences
// and a randomized run against a queue-based reference model.
module tb_pipeline_ctrl;

    localparam int          CW     = 4;
    localparam logic [31:0] VEC    = 32'hBFC0_0380;
    localparam int          CMAX   = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic          if_busy;
    logic [31:0]   exception_type;
    logic [31:0]   cp0_epc;
    logic [3:0]    stall;
    logic          exception;
    logic [31:0]   new_pc;
    logic [CW-1:0] perf_stall_cyc;
    logic [CW-1:0] perf_flush_cnt;

    int checks;
    int errors;

    pipeline_ctrl #(
        .EXC_VECTOR(VEC),
        .CNT_W     (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_if   (stallreq_if),
        .stallreq_id   (stallreq_id),
        .stallreq_ex   (stallreq_ex),
        .stallreq_mem  (stallreq_mem),
        .if_busy       (if_busy),
        .exception_type(exception_type),
        .cp0_epc       (cp0_epc),
        .stall         (stall),
        .exception     (exception),
        .new_pc        (new_pc),
        .perf_stall_cyc(perf_stall_cyc),
        .perf_flush_cnt(perf_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;      // {mem, ex, id, if}
        logic        busy;
        logic [31:0] etype;
        logic [31:0] epc;
        logic [3:0]  e_stall;
        logic        e_exc;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] r);
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = r;
    endtask

    task automatic idle_inputs();
        set_req(4'b0000);
        if_busy        = 1'b0;
        exception_type = 32'd0;
        cp0_epc        = 32'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Reference: the deepest stage requesting a stall freezes itself and all stages before it.
    function automatic logic [3:0] ref_stall(input logic [3:0] r);
        for (int b = 3; b >= 0; b--) begin
            if (r[b]) return 4'((1 << (b + 1)) - 1);
        end
        return 4'd0;
    endfunction

    function automatic int sat_add(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Reference model state
    logic [31:0] pend[$];
    bit          flush_due;
    logic [31:0] flush_tgt;
    int          m_stall, m_flush;

    int codes[8] = '{1, 4, 5, 8, 9, 10, 12, 14};

    initial begin
        logic [3:0]  e_stall;
        logic        e_exc;
        logic [31:0] e_pc;
        logic [3:0]  r;

        checks = 0;
        errors = 0;
        idle_inputs();
        rst = 1'b1;

        // Reset state, with an exception code present on the inputs
        exception_type = 32'd12;
        set_req(4'b1111);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {28'd0, stall}, 32'd0);
        chk("rst_exc", {31'd0, exception}, 32'd0);
        chk("rst_new_pc", new_pc, 32'd0);
        chk("rst_perf_stall", {28'd0, perf_stall_cyc}, 32'd0);
        chk("rst_perf_flush", {28'd0, perf_flush_cnt}, 32'd0);
        idle_inputs();
        step();
        rst = 1'b0;

        // Stall priority sequence
        set_req(4'b0010);
        @(negedge clk);
        chk("t1_id", {28'd0, stall}, 32'h3);
        step();
        set_req(4'b1010);
        @(negedge clk);
        chk("t1_id_mem", {28'd0, stall}, 32'hF);
        step();
        set_req(4'b0000);
        @(negedge clk);
        chk("t1_none", {28'd0, stall}, 32'h0);

        // Overflow exception, fetch idle
        step();
        set_req(4'b0100);
        exception_type = 32'd12;
        @(negedge clk);
        chk("t2_exc", {31'd0, exception}, 32'd1);
        chk("t2_pc", new_pc, VEC);
        chk("t2_stall", {28'd0, stall}, 32'd0);
        step();
        exception_type = 32'd0;
        set_req(4'b0000);
        @(negedge clk);
        chk("t2_next_exc", {31'd0, exception}, 32'd0);
        chk("t2_next_pc", new_pc, 32'd0);

        // Single-cycle vectors, RUN state throughout
        tbl[0] = '{4'b0001, 1'b1, 32'd0,  32'd0,         4'b0001, 1'b0, 32'd0};
        tbl[1] = '{4'b0011, 1'b0, 32'd0,  32'd0,         4'b0011, 1'b0, 32'd0};
        tbl[2] = '{4'b0111, 1'b0, 32'd0,  32'd0,         4'b0111, 1'b0, 32'd0};
        tbl[3] = '{4'b0100, 1'b1, 32'd0,  32'd0,         4'b0111, 1'b0, 32'd0};
        tbl[4] = '{4'b1001, 1'b0, 32'd0,  32'd0,         4'b1111, 1'b0, 32'd0};
        tbl[5] = '{4'b0000, 1'b0, 32'd0,  32'h1234_5678, 4'b0000, 1'b0, 32'd0};
        tbl[6] = '{4'b0000, 1'b0, 32'd14, 32'h8000_1234, 4'b0000, 1'b1, 32'h8000_1234};
        tbl[7] = '{4'b0000, 1'b0, 32'd0,  32'd0,         4'b0000, 1'b0, 32'd0};
        tbl[8] = '{4'b1111, 1'b0, 32'd4,  32'h8000_1234, 4'b0000, 1'b1, VEC};
        tbl[9] = '{4'b1000, 1'b0, 32'd0,  32'd0,         4'b1111, 1'b0, 32'd0};
        for (int i = 0; i < 10; i++) begin
            step();
            set_req(tbl[i].req);
            if_busy        = tbl[i].busy;
            exception_type = tbl[i].etype;
            cp0_epc        = tbl[i].epc;
            @(negedge clk);
            chk($sformatf("vec%0d_stall", i), {28'd0, stall}, {28'd0, tbl[i].e_stall});
            chk($sformatf("vec%0d_exc", i), {31'd0, exception}, {31'd0, tbl[i].e_exc});
            chk($sformatf("vec%0d_pc", i), new_pc, tbl[i].e_pc);
        end

        // SYSCALL while a fetch is outstanding for three cycles
        step();
        idle_inputs();
        exception_type = 32'd8;
        if_busy        = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("t4_hold%0d_stall", c), {28'd0, stall}, 32'hF);
            chk($sformatf("t4_hold%0d_exc", c), {31'd0, exception}, 32'd0);
            step();
        end
        if_busy = 1'b0;
        @(negedge clk);
        chk("t4_drain_stall", {28'd0, stall}, 32'hF);
        chk("t4_drain_exc", {31'd0, exception}, 32'd0);
        step();
        @(negedge clk);
        chk("t4_flush_exc", {31'd0, exception}, 32'd1);
        chk("t4_flush_pc", new_pc, VEC);
        chk("t4_flush_stall", {28'd0, stall}, 32'd0);
        step();
        exception_type = 32'd0;
        set_req(4'b0001);
        @(negedge clk);
        chk("t4_run_exc", {31'd0, exception}, 32'd0);
        chk("t4_run_stall", {28'd0, stall}, 32'h1);

        // Reset while waiting on the fetch discards the pending flush
        step();
        idle_inputs();
        exception_type = 32'd9;
        if_busy        = 1'b1;
        step();
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_stall", {28'd0, stall}, 32'd0);
        chk("t5_rst_exc", {31'd0, exception}, 32'd0);
        step();
        rst            = 1'b0;
        exception_type = 32'd0;
        step();
        if_busy = 1'b0;
        @(negedge clk);
        chk("t5_post_exc0", {31'd0, exception}, 32'd0);
        step();
        @(negedge clk);
        chk("t5_post_exc1", {31'd0, exception}, 32'd0);
        chk("t5_post_stall", {28'd0, stall}, 32'd0);

`ifdef PIPE_CTRL_PERF_EN
        do_reset();
        set_req(4'b0001);
        repeat (5) step();
        set_req(4'b0000);
        exception_type = 32'd1;
        step();
        exception_type = 32'd0;
        step();
        exception_type = 32'd10;
        step();
        exception_type = 32'd0;
        @(negedge clk);
        chk("t6_perf_stall", {28'd0, perf_stall_cyc}, 32'd5);
        chk("t6_perf_flush", {28'd0, perf_flush_cnt}, 32'd2);
        for (int k = 0; k < 18; k++) begin
            step();
            exception_type = 32'd12;
            step();
            exception_type = 32'd0;
            set_req(4'b0100);
        end
        step();
        set_req(4'b0000);
        @(negedge clk);
        chk("t6_sat_stall", {28'd0, perf_stall_cyc}, CMAX);
        chk("t6_sat_flush", {28'd0, perf_flush_cnt}, CMAX);
`else
        @(negedge clk);
        chk("t6_perf_stall_off", {28'd0, perf_stall_cyc}, 32'd0);
        chk("t6_perf_flush_off", {28'd0, perf_flush_cnt}, 32'd0);
`endif

        // Randomized run against the reference model
        do_reset();
        pend.delete();
        flush_due = 1'b0;
        flush_tgt = 32'd0;
        m_stall   = 0;
        m_flush   = 0;
        for (int n = 0; n < 600; n++) begin
            r              = 4'($urandom);
            set_req(r);
            if_busy        = 1'($urandom_range(0, 1));
            exception_type = ($urandom_range(0, 4) == 0) ? 32'(codes[$urandom_range(0, 7)]) : 32'd0;
            cp0_epc        = $urandom;
            @(negedge clk);

            e_stall = 4'd0;
            e_exc   = 1'b0;
            e_pc    = 32'd0;
            if (flush_due) begin
                e_exc     = 1'b1;
                e_pc      = flush_tgt;
                flush_due = 1'b0;
            end else if (pend.size() != 0) begin
                e_stall = 4'hF;
                if (!if_busy) begin
                    flush_tgt = pend.pop_front();
                    flush_due = 1'b1;
                end
            end else if (exception_type != 0) begin
                if (!if_busy) begin
                    e_exc = 1'b1;
                    e_pc  = (exception_type == 32'd14) ? cp0_epc : VEC;
                end else begin
                    e_stall = 4'hF;
                    pend.push_back((exception_type == 32'd14) ? cp0_epc : VEC);
                end
            end else begin
                e_stall = ref_stall(r);
            end

            chk("rnd_stall", {28'd0, stall}, {28'd0, e_stall});
            chk("rnd_exc", {31'd0, exception}, {31'd0, e_exc});
            chk("rnd_pc", new_pc, e_pc);
`ifdef PIPE_CTRL_PERF_EN
            chk("rnd_perf_stall", {28'd0, perf_stall_cyc}, 32'(m_stall));
            chk("rnd_perf_flush", {28'd0, perf_flush_cnt}, 32'(m_flush));
            if (e_stall != 0) m_stall = sat_add(m_stall);
            if (e_exc) m_flush = sat_add(m_flush);
`endif
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
